// File: rtl/smg_core_p_if.sv
// Byte-wide req/ack memory bus between the SMG core and its memory or bridge.
// A transfer completes in any cycle where mem_req and mem_ack are both high.
interface smg_core_p_if #(
  parameter int unsigned ADDR_W = 16
) ();
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/smg_core_p.sv
// Multicycle SMG accumulator core: control FSM and datapath for the AC/R/Z/PC/IR machine,
// talking to byte-wide memory over a req/ack bus with wait states.
module smg_core_p #(
  parameter int unsigned       DATA_W   = 8,
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  smg_core_p_if.master      bus,
  output logic [7:0]        opcode,
  output logic [DATA_W-1:0] ac_out,
  output logic              z_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              halted,
  output logic              illegal_op
);
  localparam int unsigned NB = DATA_W / 8;
  localparam int unsigned AB = ADDR_W / 8;
  localparam logic [1:0] LastNb = 2'(NB - 1);
  localparam logic [1:0] LastAb = 2'(AB - 1);
  localparam logic [ADDR_W-1:0] AbInc = ADDR_W'(AB);
  localparam logic [ADDR_W-1:0] PcOne = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] AcOne = {{(DATA_W-1){1'b0}}, 1'b1};

  localparam logic [2:0] StFetch  = 3'd0;
  localparam logic [2:0] StDecode = 3'd1;
  localparam logic [2:0] StAddr   = 3'd2;
  localparam logic [2:0] StLoad   = 3'd3;
  localparam logic [2:0] StStore  = 3'd4;
  localparam logic [2:0] StHalt   = 3'd5;

  localparam logic [7:0] OpNop  = 8'h00;
  localparam logic [7:0] OpLdac = 8'h01;
  localparam logic [7:0] OpStac = 8'h02;
  localparam logic [7:0] OpMvac = 8'h03;
  localparam logic [7:0] OpMovr = 8'h04;
  localparam logic [7:0] OpJump = 8'h05;
  localparam logic [7:0] OpJmpz = 8'h06;
  localparam logic [7:0] OpJpnz = 8'h07;
  localparam logic [7:0] OpHalt = 8'h10;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, gamma_q, gamma_d;
  logic [7:0]        ir_q, ir_d;
  logic [DATA_W-1:0] ac_q, ac_d, r_q, r_d, ld_q, ld_d;
  logic              z_q, z_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              run_q;

  logic              xfer;
  logic              taken;
  logic              alu_wr;
  logic [DATA_W-1:0] alu;
  logic [ADDR_W-1:0] gamma_nx;
  logic [DATA_W-1:0] ld_nx;

  assign xfer  = bus.mem_req & bus.mem_ack;
  assign taken = ((ir_q == OpJmpz) && z_q) || ((ir_q == OpJpnz) && !z_q);

  // Operand and load bytes arrive low byte first; the holding registers are cleared in DECODE.
  assign gamma_nx = gamma_q | (ADDR_W'(bus.mem_rdata) << {cnt_q, 3'b000});
  assign ld_nx    = ld_q | (DATA_W'(bus.mem_rdata) << {cnt_q, 3'b000});

  // Opcodes 08-0F form the flag-setting ALU group, selected by the low three bits.
  assign alu_wr = (ir_q[7:3] == 5'b00001);

  always_comb begin
    case (ir_q[2:0])
      3'd0:    alu = ac_q + r_q;
      3'd1:    alu = ac_q - r_q;
      3'd2:    alu = ac_q + AcOne;
      3'd3:    alu = '0;
      3'd4:    alu = ac_q & r_q;
      3'd5:    alu = ac_q | r_q;
      3'd6:    alu = ac_q ^ r_q;
      default: alu = ~ac_q;
    endcase
  end

  // run_q holds the bus idle until the first clock after reset release.
  always_comb begin
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (run_q) begin
      case (state_q)
        StFetch, StAddr: begin
          bus.mem_req  = 1'b1;
          bus.mem_addr = pc_q;
        end
        StLoad: begin
          bus.mem_req  = 1'b1;
          bus.mem_addr = gamma_q + ADDR_W'(cnt_q);
        end
        StStore: begin
          bus.mem_req   = 1'b1;
          bus.mem_we    = 1'b1;
          bus.mem_addr  = gamma_q + ADDR_W'(cnt_q);
          bus.mem_wdata = 8'(ac_q >> {cnt_q, 3'b000});
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ac_d       = ac_q;
    r_d        = r_q;
    z_d        = z_q;
    gamma_d    = gamma_q;
    ld_d       = ld_q;
    cnt_d      = cnt_q;
    illegal_op = 1'b0;
    case (state_q)
      StFetch: begin
        if (xfer) begin
          ir_d    = bus.mem_rdata;
          pc_d    = pc_q + PcOne;
          state_d = StDecode;
        end
      end
      StDecode: begin
        state_d = StFetch;
        cnt_d   = '0;
        gamma_d = '0;
        ld_d    = '0;
        case (ir_q)
          OpNop: ;
          OpLdac, OpStac, OpJump: state_d = StAddr;
          OpJmpz, OpJpnz: begin
            if (taken) state_d = StAddr;
            else       pc_d    = pc_q + AbInc;
          end
          OpMvac: r_d = ac_q;
          OpMovr: ac_d = r_q;
          OpHalt: state_d = StHalt;
          default: begin
            if (alu_wr) begin
              ac_d = alu;
              z_d  = (alu == '0);
            end else begin
              illegal_op = 1'b1;
            end
          end
        endcase
      end
      StAddr: begin
        if (xfer) begin
          gamma_d = gamma_nx;
          pc_d    = pc_q + PcOne;
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == LastAb) begin
            cnt_d = '0;
            case (ir_q)
              OpLdac:  state_d = StLoad;
              OpStac:  state_d = StStore;
              default: begin
                pc_d    = gamma_nx;
                state_d = StFetch;
              end
            endcase
          end
        end
      end
      StLoad: begin
        if (xfer) begin
          ld_d  = ld_nx;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == LastNb) begin
            ac_d    = ld_nx;
            cnt_d   = '0;
            state_d = StFetch;
          end
        end
      end
      StStore: begin
        if (xfer) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == LastNb) begin
            cnt_d   = '0;
            state_d = StFetch;
          end
        end
      end
      StHalt: ;
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      ac_q    <= '0;
      r_q     <= '0;
      z_q     <= 1'b0;
      gamma_q <= '0;
      ld_q    <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ac_q    <= ac_d;
      r_q     <= r_d;
      z_q     <= z_d;
      gamma_q <= gamma_d;
      ld_q    <= ld_d;
      cnt_q   <= cnt_d;
      run_q   <= 1'b1;
    end
  end

  assign opcode = ir_q;
  assign ac_out = ac_q;
  assign z_out  = z_q;
  assign pc_out = pc_q;
  assign halted = (state_q == StHalt);
endmodule

// File: tb/tb_smg_core_p.sv
// Directed bench for smg_core_p: an 8-bit core and a 16-bit core share one byte memory model,
// only one of them out of reset at a time, so their bus outputs can simply be OR-ed.
module tb_smg_core_p;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst8, rst16;
  smg_core_p_if #(.ADDR_W(16)) bus8 ();
  smg_core_p_if #(.ADDR_W(16)) bus16 ();

  logic [7:0]  op8, op16, ac8;
  logic [15:0] ac16, pc8, pc16;
  logic        z8, z16, halt8, halt16, ill8, ill16;

  smg_core_p #(.DATA_W(8), .ADDR_W(16), .RESET_PC(16'h0000)) u_dut8 (
    .clk(clk), .reset(rst8), .bus(bus8), .opcode(op8), .ac_out(ac8), .z_out(z8),
    .pc_out(pc8), .halted(halt8), .illegal_op(ill8)
  );

  smg_core_p #(.DATA_W(16), .ADDR_W(16), .RESET_PC(16'h0010)) u_dut16 (
    .clk(clk), .reset(rst16), .bus(bus16), .opcode(op16), .ac_out(ac16), .z_out(z16),
    .pc_out(pc16), .halted(halt16), .illegal_op(ill16)
  );

  logic        req, we, ack;
  logic [15:0] addr;
  logic [7:0]  wdata, rdata;
  logic [7:0]  mem [0:65535];

  assign req   = bus8.mem_req | bus16.mem_req;
  assign we    = bus8.mem_we | bus16.mem_we;
  assign addr  = bus8.mem_addr | bus16.mem_addr;
  assign wdata = bus8.mem_wdata | bus16.mem_wdata;
  assign rdata = mem[addr];
  assign bus8.mem_rdata  = rdata;
  assign bus16.mem_rdata = rdata;
  assign bus8.mem_ack    = ack;
  assign bus16.mem_ack   = ack;

  int unsigned wmin = 0, wmax = 0, wcnt = 0, wtarget = 0;
  assign ack = req && (wcnt >= wtarget);

  logic [15:0] wr_addr [0:63];
  logic [7:0]  wr_data [0:63];
  int          wr_n = 0, stab_err = 0, wait_cyc = 0, req_cyc = 0, ill_cnt = 0;
  logic        pend = 1'b0, p_we = 1'b0;
  logic [15:0] p_addr = '0;
  logic [7:0]  p_wdata = '0;

  // Memory responder and bus monitor; writes are logged rather than stored.
  always @(posedge clk) begin
    if (req && ack) begin
      wcnt    <= 0;
      wtarget <= $urandom_range(wmax, wmin);
      if (we) begin
        wr_addr[wr_n[5:0]] <= addr;
        wr_data[wr_n[5:0]] <= wdata;
        wr_n <= wr_n + 1;
      end
    end else if (req) begin
      wcnt <= wcnt + 1;
    end else begin
      wcnt    <= 0;
      wtarget <= $urandom_range(wmax, wmin);
    end
    if (pend && req && (addr !== p_addr || we !== p_we || wdata !== p_wdata))
      stab_err <= stab_err + 1;
    pend    <= req && !ack;
    p_addr  <= addr;
    p_we    <= we;
    p_wdata <= wdata;
    if (req && !ack) wait_cyc <= wait_cyc + 1;
    if (req) req_cyc <= req_cyc + 1;
    if (ill8 || ill16) ill_cnt <= ill_cnt + 1;
  end

  int pass_cnt = 0, total_cnt = 0;

  task automatic clear_mem();
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
  endtask

  // First byte of the program sits in the most significant used byte of 'bytes'.
  task automatic load(input int base, input logic [127:0] bytes, input int n);
    for (int i = 0; i < n; i++) mem[(base + i) & 16'hFFFF] = bytes[8*(n-1-i) +: 8];
  endtask

  task automatic start(input bit sel16);
    rst8 = 1'b0;
    rst16 = 1'b0;
    repeat (2) @(negedge clk);
    if (sel16) rst16 = 1'b1;
    else       rst8  = 1'b1;
  endtask

  task automatic wait_halt(output bit ok);
    int n = 0;
    while (!(halt8 || halt16) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    ok = halt8 || halt16;
  endtask

  task automatic wait_fetch(input logic [15:0] a, output bit ok);
    int n = 0;
    while (!(req && !we && addr == a) && n < 300) begin
      @(negedge clk);
      n++;
    end
    ok = req && !we && addr == a;
  endtask

  task automatic test_reset();
    rst8 = 1'b0;
    rst16 = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if (pc16 !== 16'h0010) $display("FAIL reset_pc16: got %h want 0010", pc16); else pass_cnt++;
    total_cnt++;
    if ({pc8, ac8, op8} !== 32'h0) $display("FAIL reset_pc_ac_ir8: got %h want 0", {pc8, ac8, op8});
    else pass_cnt++;
    total_cnt++;
    if ({z8, halt8, ill8, req} !== 4'b0) $display("FAIL reset_flags: got %b want 0000",
                                                  {z8, halt8, ill8, req});
    else pass_cnt++;
    total_cnt++;
    if ({addr, ac16} !== 32'h0) $display("FAIL reset_addr_ac16: got %h want 0", {addr, ac16});
    else pass_cnt++;
  endtask

  task automatic run_prog1(input string tag);
    bit ok;
    int n = 0;
    clear_mem();
    load(0, {8'h01, 8'h00, 8'h01, 8'h03, 8'h0A, 8'h08, 8'h10}, 7);
    mem[16'h0100] = 8'h05;
    start(1'b0);
    wait_fetch(16'h0000, ok);
    total_cnt++;
    if (ok !== 1'b1) $display("FAIL %s_first_fetch: got %b want 1", tag, ok); else pass_cnt++;
    while (!(req && !we && addr == 16'h0003) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (wmax == 0) begin
      total_cnt++;
      if (n !== 5) $display("FAIL %s_ldac_cycles: got %0d want 5", tag, n); else pass_cnt++;
    end
    wait_halt(ok);
    total_cnt++;
    if (ok !== 1'b1) $display("FAIL %s_halt: got %b want 1", tag, ok); else pass_cnt++;
    total_cnt++;
    if ({ac8, z8} !== {8'h0B, 1'b0}) $display("FAIL %s_ac_z: got %h/%b want 0b/0", tag, ac8, z8);
    else pass_cnt++;
    total_cnt++;
    if (pc8 !== 16'h0007) $display("FAIL %s_pc: got %h want 0007", tag, pc8); else pass_cnt++;
  endtask

  task automatic test_program1();
    wmin = 0;
    wmax = 0;
    run_prog1("prog1");
  endtask

  task automatic test_branch();
    bit ok;
    wmin = 0;
    wmax = 0;
    clear_mem();
    load(16'h0000, {8'h0B, 8'h06, 8'h40, 8'h00}, 4);
    load(16'h0040, {8'h0A, 8'h07, 8'h60, 8'h00}, 4);
    load(16'h0060, {8'h06, 8'h00, 8'h01, 8'h05, 8'h80, 8'h00}, 6);
    mem[16'h0080] = 8'h10;
    start(1'b0);
    wait_fetch(16'h0040, ok);
    total_cnt++;
    if (ok !== 1'b1) $display("FAIL jmpz_taken_target: got %b want 1", ok); else pass_cnt++;
    total_cnt++;
    if ({z8, ac8} !== {1'b1, 8'h00}) $display("FAIL clac_z: got %b/%h want 1/00", z8, ac8);
    else pass_cnt++;
    wait_fetch(16'h0060, ok);
    total_cnt++;
    if (ok !== 1'b1) $display("FAIL jpnz_taken_target: got %b want 1", ok); else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (req !== 1'b0) $display("FAIL nt_decode_idle: got req %b want 0", req); else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({req, we, addr} !== {2'b10, 16'h0063})
      $display("FAIL nt_next_fetch: got req %b addr %h want 1/0063", req, addr);
    else pass_cnt++;
    wait_halt(ok);
    total_cnt++;
    if ({ok, pc8, ac8, z8} !== {1'b1, 16'h0081, 8'h01, 1'b0})
      $display("FAIL branch_final: got halt %b pc %h ac %h z %b want 1/0081/01/0", ok, pc8, ac8, z8);
    else pass_cnt++;
  endtask

  task automatic test_alu();
    bit ok;
    int w0;
    wmin = 0;
    wmax = 0;
    clear_mem();
    load(0, {8'h01, 8'h00, 8'h01, 8'h03, 8'h0F, 8'h0D, 8'h0E, 8'h0C, 8'h04, 8'h10}, 10);
    mem[16'h0100] = 8'h3C;
    start(1'b0);
    wait_halt(ok);
    total_cnt++;
    if ({ok, ac8, z8} !== {1'b1, 8'h3C, 1'b1})
      $display("FAIL logic_movr: got halt %b ac %h z %b want 1/3c/1", ok, ac8, z8);
    else pass_cnt++;
    clear_mem();
    load(0, {8'h01, 8'h00, 8'h01, 8'h03, 8'h0B, 8'h0A, 8'h09, 8'h02, 8'h80, 8'h00, 8'h10}, 11);
    mem[16'h0100] = 8'h3C;
    w0 = wr_n;
    start(1'b0);
    wait_halt(ok);
    total_cnt++;
    if ({ok, ac8, z8, pc8} !== {1'b1, 8'hC5, 1'b0, 16'h000B})
      $display("FAIL sub_wrap: got halt %b ac %h z %b pc %h want 1/c5/0/000b", ok, ac8, z8, pc8);
    else pass_cnt++;
    total_cnt++;
    if ({wr_n - w0, wr_addr[w0[5:0]], wr_data[w0[5:0]]} !== {32'd1, 16'h0080, 8'hC5})
      $display("FAIL stac8: got n %0d @%h=%h want 1 @0080=c5", wr_n - w0, wr_addr[w0[5:0]],
               wr_data[w0[5:0]]);
    else pass_cnt++;
  endtask

  task automatic test_wait_states();
    int s0, c0;
    wmin = 0;
    wmax = 3;
    s0 = stab_err;
    c0 = wait_cyc;
    run_prog1("waits");
    total_cnt++;
    if (stab_err - s0 !== 0) $display("FAIL bus_stable: got %0d changes want 0", stab_err - s0);
    else pass_cnt++;
    total_cnt++;
    if ((wait_cyc > c0) !== 1'b1) $display("FAIL waits_seen: got %0d want >0", wait_cyc - c0);
    else pass_cnt++;
    wmax = 0;
  endtask

  task automatic test_data16();
    bit ok;
    int w0;
    wmin = 0;
    wmax = 0;
    clear_mem();
    load(16'h0010, {8'h01, 8'h00, 8'h02, 8'h02, 8'hFF, 8'hFF, 8'h10}, 7);
    mem[16'h0200] = 8'h34;
    mem[16'h0201] = 8'h12;
    w0 = wr_n;
    start(1'b1);
    wait_halt(ok);
    total_cnt++;
    if ({ok, ac16, pc16} !== {1'b1, 16'h1234, 16'h0017})
      $display("FAIL ldac16: got halt %b ac %h pc %h want 1/1234/0017", ok, ac16, pc16);
    else pass_cnt++;
    total_cnt++;
    if (wr_n - w0 !== 2) $display("FAIL stac16_count: got %0d want 2", wr_n - w0); else pass_cnt++;
    total_cnt++;
    if ({wr_addr[w0[5:0]], wr_data[w0[5:0]], wr_addr[w0[5:0] + 6'd1], wr_data[w0[5:0] + 6'd1]}
        !== {16'hFFFF, 8'h34, 16'h0000, 8'h12})
      $display("FAIL stac16_wrap: got %h=%h %h=%h want ffff=34 0000=12", wr_addr[w0[5:0]],
               wr_data[w0[5:0]], wr_addr[w0[5:0] + 6'd1], wr_data[w0[5:0] + 6'd1]);
    else pass_cnt++;
  endtask

  task automatic test_wrap_illegal();
    bit ok;
    int i0, r0;
    wmin = 0;
    wmax = 0;
    clear_mem();
    load(0, {8'h0B, 8'h0F, 8'h0A, 8'h7F, 8'h10}, 5);
    i0 = ill_cnt;
    start(1'b0);
    wait_halt(ok);
    total_cnt++;
    if ({ok, ac8, z8} !== {1'b1, 8'h00, 1'b1})
      $display("FAIL inac_wrap: got halt %b ac %h z %b want 1/00/1", ok, ac8, z8);
    else pass_cnt++;
    total_cnt++;
    if (ill_cnt - i0 !== 1) $display("FAIL illegal_pulse: got %0d want 1", ill_cnt - i0);
    else pass_cnt++;
    total_cnt++;
    if ({pc8, op8} !== {16'h0005, 8'h10}) $display("FAIL halt_pc: got %h/%h want 0005/10", pc8, op8);
    else pass_cnt++;
    r0 = req_cyc;
    repeat (20) @(negedge clk);
    total_cnt++;
    if ({req_cyc - r0, halt8} !== {32'd0, 1'b1})
      $display("FAIL halt_quiet: got %0d reqs halted %b want 0/1", req_cyc - r0, halt8);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int w0, n = 0;
    wmin = 6;
    wmax = 6;
    clear_mem();
    load(16'h0010, {8'h02, 8'h00, 8'h03, 8'h10}, 4);
    w0 = wr_n;
    start(1'b1);
    while (!(req && we) && n < 300) begin
      @(negedge clk);
      n++;
    end
    total_cnt++;
    if ((req && we) !== 1'b1) $display("FAIL store_started: got %b want 1", req && we);
    else pass_cnt++;
    @(negedge clk);
    #2 rst16 = 1'b0;
    #1;
    total_cnt++;
    if ({req, pc16, op16} !== {1'b0, 16'h0010, 8'h00})
      $display("FAIL reset_drop: got req %b pc %h ir %h want 0/0010/00", req, pc16, op16);
    else pass_cnt++;
    wmin = 0;
    wmax = 0;
    @(negedge clk);
    total_cnt++;
    if (wr_n - w0 !== 0) $display("FAIL abandoned_write: got %0d want 0", wr_n - w0); else pass_cnt++;
    rst16 = 1'b1;
    wait_fetch(16'h0010, ok);
    total_cnt++;
    if (ok !== 1'b1) $display("FAIL refetch: got %b want 1", ok); else pass_cnt++;
    wait_halt(ok);
    total_cnt++;
    if ({ok, wr_n - w0} !== {1'b1, 32'd2})
      $display("FAIL restart_store: got halt %b writes %0d want 1/2", ok, wr_n - w0);
    else pass_cnt++;
  endtask

  initial begin
    rst8 = 1'b0;
    rst16 = 1'b0;
    test_reset();
    test_program1();
    test_branch();
    test_alu();
    test_data16();
    test_wrap_illegal();
    test_wait_states();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
